// File: rtl/demux_pkg.sv
// Shared lane and mode definitions for the 1:4 demux dispatch sequencer.
// Pure declarations, no logic.
package demux_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/lane_counter.sv
// Saturating per-lane beat counter; clr has priority over inc.
// Latency: count visible the cycle after inc; no backpressure.
module lane_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-entry holding register that steers beats to 4 lanes in bursts (round-robin or fixed).
// Latency 1 cycle; in_ready follows the held lane's out_ready so a drain and accept can share a cycle.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic [NUM_LANES-1:0]         out_ready,
    output logic [NUM_LANES-1:0]         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [1:0]                   sel,
    input  logic                         mode,
    input  logic [1:0]                   fixed_sel,
    input  logic                         cnt_clr,
    output logic [NUM_LANES*CNT_W-1:0]   lane_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic          hold_valid;
    lane_t         hold_lane;
    lane_t         cur_lane;
    logic [BW-1:0] burst_cnt;
    lane_t         target;
    logic          accept;
    logic          drain;

    assign drain    = (hold_valid == ST_FULL) && out_ready[hold_lane];
    assign in_ready = !rst && ((hold_valid == ST_EMPTY) || out_ready[hold_lane]);
    assign accept   = in_valid && in_ready;
    assign target   = (mode == MODE_FIXED) ? fixed_sel : cur_lane;
    assign sel      = hold_lane;

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            out_valid[i] = hold_valid && (hold_lane == lane_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= ST_EMPTY;
            hold_lane  <= '0;
            cur_lane   <= '0;
            burst_cnt  <= '0;
            out_data   <= '0;
        end else if (accept) begin
            hold_valid <= ST_FULL;
            hold_lane  <= target;
            out_data   <= in_data;
            // Fixed mode abandons any partial burst so round-robin later restarts cleanly.
            if (mode == MODE_FIXED) begin
                burst_cnt <= '0;
            end else if (burst_cnt == BW'(BURST_LEN - 1)) begin
                burst_cnt <= '0;
                cur_lane  <= cur_lane + lane_t'(1);
            end else begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end else if (drain) begin
            hold_valid <= ST_EMPTY;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_cnt
        lane_counter #(
            .CNT_W (CNT_W)
        ) u_lane_counter (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (drain && (hold_lane == lane_t'(i))),
            .cnt (lane_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
